// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and decode helpers for the seg7 receive path.
// Bit order of every pattern: bit0 = segment a .. bit6 = segment g, 1 = lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef struct packed {
    logic [3:0] code;
    logic       blank;
    logic       pat_err;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
    seg7_dec_t d;
    d.blank   = 1'b0;
    d.pat_err = 1'b0;
    case (pat)
      SEG_0:     d.code = 4'd0;
      SEG_1:     d.code = 4'd1;
      SEG_2:     d.code = 4'd2;
      SEG_3:     d.code = 4'd3;
      SEG_4:     d.code = 4'd4;
      SEG_5:     d.code = 4'd5;
      SEG_6:     d.code = 4'd6;
      SEG_7:     d.code = 4'd7;
      SEG_8:     d.code = 4'd8;
      SEG_9:     d.code = 4'd9;
      SEG_BLANK: begin
        d.code  = CODE_BLANK;
        d.blank = 1'b1;
      end
      default: begin
        d.code    = CODE_ERR;
        d.pat_err = 1'b1;
      end
    endcase
    return d;
  endfunction

  // Counting order: 0..9, then blank, then back to 0.
  function automatic logic [3:0] seg7_next_code(input logic [3:0] code);
    logic [3:0] n;
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: n = code + 4'd1;
      4'd9:                   n = CODE_BLANK;
      CODE_BLANK:             n = 4'd0;
      default:                n = CODE_ERR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seg7_glitch_filter.sv
// Synchronizes the raw segment pins and accepts a pattern once it has been
// seen on STABLE_CYCLES consecutive qualified samples and differs from the last one.
module seg7_glitch_filter import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic       accept,
  output logic [6:0] accept_pat
);

  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  logic [6:0] s1;
  logic [6:0] s2;
  logic [6:0] cand;
  logic [3:0] cnt;
  logic [6:0] last_pat;
  logic       has_acc;
  logic       stable_hit;

  // With a one-sample window any change is already stable.
  always_comb begin
    stable_hit = 1'b0;
    if (STABLE_CYCLES == 1) stable_hit = (s2 != cand);
    else                    stable_hit = (s2 == cand) && (cnt == CNT_LAST);
  end

  assign accept     = sample_en && stable_hit && (!has_acc || (s2 != last_pat));
  assign accept_pat = s2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1       <= '0;
      s2       <= '0;
      cand     <= '0;
      cnt      <= '0;
      last_pat <= '0;
      has_acc  <= 1'b0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      if (sample_en) begin
        if (s2 != cand) begin
          cand <= s2;
          cnt  <= 4'd1;
        end else if (cnt < CNT_MAX) begin
          cnt <= cnt + 4'd1;
        end
      end
      if (accept) begin
        has_acc  <= 1'b1;
        last_pat <= s2;
      end
    end
  end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Seven-segment receiver: filtered pattern acceptance, digit decode and error counting.
// Define SEG7_RX_SEQ_CHECK_EN to add counting-order checking (seq_err).
module seg7_rx_decoder import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       blank,
  output logic       pat_err,
  output logic       seq_err,
  output logic [7:0] err_count
);

  logic      accept;
  logic [6:0] acc_pat;
  seg7_dec_t dec;
  logic      seq_hit;

  seg7_glitch_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .rstn       (rstn),
    .seg_in     (seg_in),
    .sample_en  (sample_en),
    .accept     (accept),
    .accept_pat (acc_pat)
  );

  assign dec = seg7_decode(acc_pat);

`ifdef SEG7_RX_SEQ_CHECK_EN
  logic       exp_valid;
  logic [3:0] exp_code;

  // An invalid pattern leaves nothing to expect, so the next accept is free.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exp_valid <= 1'b0;
      exp_code  <= '0;
    end else if (accept) begin
      exp_valid <= (dec.code != CODE_ERR);
      exp_code  <= seg7_next_code(dec.code);
    end
  end

  assign seq_hit = exp_valid && (dec.code != exp_code);
`else
  assign seq_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      digit_out   <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      pat_err     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      digit_valid <= accept;
      seq_err     <= accept && seq_hit;
      if (accept) begin
        digit_out <= dec.code;
        blank     <= dec.blank;
        pat_err   <= dec.pat_err;
        if ((dec.pat_err || seq_hit) && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
